z_fetch: RTL and testbench

Instruction fetch stage of the single-issue core. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents one fetched instruction at a time with its PC to the downstream `z_decoder`. It applies jump and taken-branch redirects from later stages, flushing the held instruction and discarding any in-flight read.

---
 rtl/z_fetch.sv | 157 +++++++++++++++
 tb/tb_z_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z_fetch.sv
// z_fetch: instruction fetch stage of the single-issue core.
// Holds the fetch PC, issues word reads over an imem req/ack handshake and
// presents one instruction at a time (with its PC) to z_decoder. Jump and
// taken-branch redirects flush the held instruction. A read that is already
// in flight is allowed to complete, and its data is thrown away.
// Optional build macro: Z_FETCH_PERF_EN adds a saturating stall_cnt output.
module z_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_out,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target
`ifdef Z_FETCH_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ins_q, ins_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_out_q, pc_out_d;

    logic        redirect;
    logic [31:0] target;

    // Jump has priority over a taken branch. Targets are forced word-aligned.
    always_comb begin
        redirect = jump | branch_taken;
        target   = (jump ? jump_target : branch_target) & ~32'h3;
    end

    // Next-state and next-output computation for the fetch controller.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        ins_d    = ins_q;
        valid_d  = valid_q;
        pc_out_d = pc_out_q;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    // If a redirect arrives in the ack cycle, the returning word is stale.
                    // In that case we stay in FETCH so a new request goes out at the target.
                    if (!redirect) begin
                        ins_d    = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = FULL;
                    end
                end else if (redirect) begin
                    // A request cannot be withdrawn, so we wait out its ack.
                    state_d = DRAIN;
                end
            end
            FULL: begin
                if (valid_q && ins_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // A redirect always retargets the PC and flushes the held slot.
        // If the redirect arrives in FULL, the slot is now empty, so fetch immediately.
        if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
            if (state_q == FULL) state_d = FETCH;
        end

        // Request is live in FETCH and DRAIN.
        // The address only changes when a fresh FETCH request starts.
        // In DRAIN it keeps the squashed address.
        req_d = (state_d == FETCH) || (state_d == DRAIN);
        if (state_d == FETCH) addr_d = pc_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            ins_q    <= 32'h0;
            valid_q  <= 1'b0;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            ins_q    <= ins_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ins_out   = ins_q;
    assign ins_valid = valid_q;
    assign pc_out    = pc_out_q;
    assign pc_plus4  = pc_out_q + 32'd4;

`ifdef Z_FETCH_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Count cycles where the decoder holds off a live instruction.
    // The count saturates at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (valid_q && !ins_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= 16'h0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_z_fetch.sv
// Self-checking bench for z_fetch: directed vector table, reset/wrap sequences,
// then randomized traffic against a transaction-level reference model.
module tb_z_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req, imem_ack, ins_valid, ins_ready, jump, branch_taken;
    logic [31:0] imem_addr, imem_rdata, ins_out, pc_out, pc_plus4, jump_target, branch_target;

    logic        req2, valid2;
    logic [31:0] addr2, ins2, pc2, p4_2;
    logic        ack2 = 1'b1, ready2 = 1'b1, zero1 = 1'b0;
    logic [31:0] rdata2 = 32'h1234_5678, zero32 = 32'h0;
`ifdef Z_FETCH_PERF_EN
    logic [15:0] stall_cnt, stall_cnt2;
`endif

    always #5 clk = ~clk;

    z_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ins_out(ins_out),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .pc_out(pc_out),
        .pc_plus4(pc_plus4), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef Z_FETCH_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    z_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .ins_out(ins2),
        .ins_valid(valid2), .ins_ready(ready2), .pc_out(pc2),
        .pc_plus4(p4_2), .jump(zero1), .jump_target(zero32),
        .branch_taken(zero1), .branch_target(zero32)
`ifdef Z_FETCH_PERF_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding-read record, one output slot, and a fetch PC.
    logic        m_req, m_squash, m_valid;
    logic [31:0] m_addr, m_pc, m_ins, m_pcout;
    int          m_stall;

    task automatic model_reset();
        m_req = 0; m_squash = 0; m_valid = 0;
        m_addr = 0; m_pc = 0; m_ins = 0; m_pcout = 0; m_stall = 0;
    endtask

    task automatic model_step();
        logic        redir, acked, keep, nv;
        logic [31:0] tgt;
        redir = jump | branch_taken;
        tgt   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
        acked = m_req && imem_ack;
        keep  = m_req && !imem_ack;
        nv    = m_valid;
        if (m_valid && !ins_ready && m_stall < 65535) m_stall++;
        if (m_valid && ins_ready) nv = 0;
        if (acked && !m_squash && !redir) begin
            m_ins = imem_rdata; m_pcout = m_addr; nv = 1; m_pc = m_addr + 32'd4;
        end
        if (redir) begin
            m_pc = tgt; nv = 0;
            if (keep) m_squash = 1;
        end
        m_valid = nv;
        if (!keep) begin
            if (!m_valid) begin
                m_req = 1; m_addr = m_pc; m_squash = 0;
            end else begin
                m_req = 0;
            end
        end
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        j;
        logic [31:0] jt;
        logic        b;
        logic [31:0] bt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] eins;
        logic [31:0] epc;
        int          estall;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic ack, input logic [31:0] rd, input logic rdy,
                                input logic j, input logic [31:0] jt, input logic b,
                                input logic [31:0] bt, input logic ereq, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                                input int es);
        vec_t v;
        v.ack = ack; v.rdata = rd; v.ready = rdy; v.j = j; v.jt = jt; v.b = b; v.bt = bt;
        v.ereq = ereq; v.eaddr = ea; v.evalid = ev; v.eins = ei; v.epc = ep; v.estall = es;
        return v;
    endfunction

    task automatic drive(input logic ack, input logic [31:0] rd, input logic rdy,
                         input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
        imem_ack = ack; imem_rdata = rd; ins_ready = rdy;
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    endtask

    initial begin
        //            ack rdata          rdy j jt      b bt       req addr     v ins            pc      stall
        tbl[0]  = mk(1, 32'h0,          1, 0, 0,      0, 0,      1, 32'h0,    0, 0,             0,      0);
        tbl[1]  = mk(1, 32'h1022_1821,  1, 0, 0,      0, 0,      0, 0,        1, 32'h1022_1821, 32'h0,  0);
        tbl[2]  = mk(1, 32'h9999_9999,  1, 0, 0,      0, 0,      1, 32'h4,    0, 0,             0,      0);
        tbl[3]  = mk(1, 32'hAAAA_0001,  0, 0, 0,      0, 0,      0, 0,        1, 32'hAAAA_0001, 32'h4,  0);
        tbl[4]  = mk(0, 32'h0,          0, 0, 0,      0, 0,      0, 0,        1, 32'hAAAA_0001, 32'h4,  1);
        tbl[5]  = mk(0, 32'h0,          0, 0, 0,      0, 0,      0, 0,        1, 32'hAAAA_0001, 32'h4,  2);
        tbl[6]  = mk(0, 32'h0,          0, 0, 0,      0, 0,      0, 0,        1, 32'hAAAA_0001, 32'h4,  3);
        tbl[7]  = mk(0, 32'h0,          0, 0, 0,      0, 0,      0, 0,        1, 32'hAAAA_0001, 32'h4,  4);
        tbl[8]  = mk(0, 32'h0,          0, 0, 0,      0, 0,      0, 0,        1, 32'hAAAA_0001, 32'h4,  5);
        tbl[9]  = mk(0, 32'h0,          1, 0, 0,      0, 0,      1, 32'h8,    0, 0,             0,      5);
        tbl[10] = mk(0, 32'h0,          1, 0, 0,      0, 0,      1, 32'h8,    0, 0,             0,      5);
        tbl[11] = mk(0, 32'h0,          1, 0, 0,      0, 0,      1, 32'h8,    0, 0,             0,      5);
        tbl[12] = mk(0, 32'h0,          1, 0, 0,      0, 0,      1, 32'h8,    0, 0,             0,      5);
        tbl[13] = mk(1, 32'hBBBB_0008,  1, 0, 0,      0, 0,      0, 0,        1, 32'hBBBB_0008, 32'h8,  5);
        tbl[14] = mk(0, 32'h0,          0, 1, 32'h103,0, 0,      1, 32'h100,  0, 0,             0,      6);
        tbl[15] = mk(0, 32'h0,          1, 0, 0,      0, 0,      1, 32'h100,  0, 0,             0,      6);
        tbl[16] = mk(1, 32'hCCCC_0100,  1, 0, 0,      0, 0,      0, 0,        1, 32'hCCCC_0100, 32'h100,6);
        tbl[17] = mk(0, 32'h0,          1, 0, 0,      0, 0,      1, 32'h104,  0, 0,             0,      6);
        tbl[18] = mk(0, 32'h0,          1, 0, 0,      1, 32'h40, 1, 32'h104,  0, 0,             0,      6);
        tbl[19] = mk(0, 32'h0,          1, 0, 0,      0, 0,      1, 32'h104,  0, 0,             0,      6);
        tbl[20] = mk(1, 32'hDEAD_BEEF,  1, 0, 0,      0, 0,      1, 32'h40,   0, 0,             0,      6);
        tbl[21] = mk(1, 32'h4040_4040,  1, 1, 32'h200,1, 32'h300,1, 32'h200,  0, 0,             0,      6);
        tbl[22] = mk(1, 32'h2222_2222,  1, 0, 0,      0, 0,      0, 0,        1, 32'h2222_2222, 32'h200,6);
        tbl[23] = mk(0, 32'h0,          1, 0, 0,      0, 0,      1, 32'h204,  0, 0,             0,      6);
        tbl[24] = mk(0, 32'h0,          1, 0, 0,      1, 32'h80, 1, 32'h204,  0, 0,             0,      6);

        drive(1, 32'h5555_5555, 1, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ins", ins_out, 32'h0);
        chk("rst_valid", {31'h0, ins_valid}, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst2_addr", addr2, 32'hFFFF_FFFC);
`ifdef Z_FETCH_PERF_EN
        chk("rst_stall", {16'h0, stall_cnt}, 32'h0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].ack, tbl[i].rdata, tbl[i].ready, tbl[i].j, tbl[i].jt, tbl[i].b, tbl[i].bt);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].ereq});
            if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d_valid", i), {31'h0, ins_valid}, {31'h0, tbl[i].evalid});
            if (tbl[i].evalid) begin
                chk($sformatf("tbl%0d_ins", i), ins_out, tbl[i].eins);
                chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].epc);
                chk($sformatf("tbl%0d_pc4", i), pc_plus4, tbl[i].epc + 32'd4);
            end
`ifdef Z_FETCH_PERF_EN
            chk($sformatf("tbl%0d_stall", i), {16'h0, stall_cnt}, 32'(tbl[i].estall));
`endif
            // Wrap instance, zero-wait memory, always ready.
            if (i == 0) begin
                chk("wrap_req0", {31'h0, req2}, 32'h1);
                chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
            end
            if (i == 1) begin
                chk("wrap_valid", {31'h0, valid2}, 32'h1);
                chk("wrap_pc", pc2, 32'hFFFF_FFFC);
                chk("wrap_pc4", p4_2, 32'h0);
            end
            if (i == 2) chk("wrap_addr1", addr2, 32'h0);
        end

        // Reset pulsed while DRAIN has a squashed read outstanding.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", {31'h0, ins_valid}, 32'h0);
        chk("mid_rst_ins", ins_out, 32'h0);
        chk("mid_rst_pc", pc_out, 32'h0);
        drive(1, 32'h7777_7777, 1, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_req", {31'h0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_valid", {31'h0, ins_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_fill", {31'h0, ins_valid}, 32'h1);
        chk("post_rst_ins", ins_out, 32'h7777_7777);

        // Randomized traffic vs reference model.
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(99) < 50), $urandom, ($urandom_range(99) < 70),
                  ($urandom_range(99) < 5), $urandom, ($urandom_range(99) < 6), $urandom);
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_req", {31'h0, imem_req}, {31'h0, m_req});
            if (m_req) chk("rnd_addr", imem_addr, m_addr);
            chk("rnd_valid", {31'h0, ins_valid}, {31'h0, m_valid});
            if (m_valid) begin
                chk("rnd_ins", ins_out, m_ins);
                chk("rnd_pc", pc_out, m_pcout);
                chk("rnd_pc4", pc_plus4, m_pcout + 32'd4);
            end
`ifdef Z_FETCH_PERF_EN
            chk("rnd_stall", {16'h0, stall_cnt}, 32'(m_stall));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
